// File: rtl/prj_pkg.sv
// Shared definitions for the prj_b counter and its control sequencer.
package prj_pkg;

    localparam int unsigned NC_DEFAULT = 32'd2;
    localparam int unsigned CTRL_IDLE  = 32'd0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Power-up schedule: entry i holds code i, wrapped to the code width.
    function automatic int unsigned entry_reset_code(input int unsigned idx, input int unsigned nc);
        return idx % (32'd1 << nc);
    endfunction

endpackage

// File: rtl/prj_dwell_timer.sv
// Counts the cycles a schedule entry has been held; tc flags the last cycle of a DWELL window.
module prj_dwell_timer #(
    parameter int unsigned DWELL = 32'd25
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int unsigned     DW     = (DWELL > 32'd1) ? $clog2(DWELL) : 32'd1;
    localparam logic [DW-1:0]   TC_VAL = DW'(DWELL - 32'd1);
    localparam logic [DW-1:0]   ONE    = DW'(1'b1);

    logic [DW-1:0] cnt_r;

    // Dwell counter: cleared on load, otherwise climbs until it reaches the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {DW{1'b0}};
        end else if (load) begin
            cnt_r <= {DW{1'b0}};
        end else if (en && !tc) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/prj_ctrl_seq.sv
// Steps the prj_b ctrl input through a loadable table, holding each code DWELL cycles.
// Define PRJ_CTRL_SEQ_LOOP_EN to repeat the schedule until stop instead of a single pass.
module prj_ctrl_seq
    import prj_pkg::*;
#(
    parameter  int unsigned Nc    = NC_DEFAULT,
    parameter  int unsigned STEPS = 32'd4,
    parameter  int unsigned DWELL = 32'd25,
    localparam int unsigned AW    = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [Nc-1:0] wr_data,
    input  logic          start,
    input  logic          stop,
    output logic [Nc-1:0] ctrl,
    output logic [AW-1:0] step,
    output logic          busy,
    output logic          done
);

    localparam logic [Nc-1:0] CTRL_OFF   = Nc'(CTRL_IDLE);
    localparam logic [AW-1:0] STEP_FIRST = {AW{1'b0}};
    localparam logic [AW-1:0] STEP_LAST  = AW'(STEPS - 32'd1);
    localparam logic [AW-1:0] STEP_ONE   = AW'(1'b1);
    localparam logic [AW:0]   STEPS_W    = (AW+1)'(STEPS);

    seq_state_t    state_r;
    logic [Nc-1:0] tbl_r [STEPS];
    logic          load_s;
    logic          en_s;
    logic          tc_s;
    logic          wr_ok_s;
    logic          last_s;
    logic [AW-1:0] next_step_s;

    assign wr_ok_s     = ({1'b0, wr_addr} < STEPS_W);
    assign last_s      = (step == STEP_LAST);
    assign next_step_s = step + STEP_ONE;

    // Schedule storage; a write lands at the next edge and is only seen when its entry is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STEPS); i++) begin
                tbl_r[i] <= Nc'(entry_reset_code(i, Nc));
            end
        end else if (wr_en && wr_ok_s) begin
            tbl_r[wr_addr] <= wr_data;
        end
    end

    // Dwell timer control: restart on entering a sequence, on each advance and on abort.
    always_comb begin
        load_s = 1'b0;
        en_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !stop) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            RUN: begin
                en_s = 1'b1;
                if (stop || tc_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b1;
                en_s   = 1'b0;
            end
        endcase
    end

    prj_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .load (load_s),
        .en   (en_s),
        .tc   (tc_s)
    );

    // Sequencer FSM with registered ctrl/step/busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ctrl    <= CTRL_OFF;
            step    <= STEP_FIRST;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start && !stop) begin
                        state_r <= RUN;
                        ctrl    <= tbl_r[STEP_FIRST];
                        step    <= STEP_FIRST;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_r <= IDLE;
                        ctrl    <= CTRL_OFF;
                        step    <= STEP_FIRST;
                        busy    <= 1'b0;
                    end else if (tc_s) begin
                        if (last_s) begin
                            done <= 1'b1;
                            step <= STEP_FIRST;
`ifdef PRJ_CTRL_SEQ_LOOP_EN
                            ctrl <= tbl_r[STEP_FIRST];
`else
                            state_r <= IDLE;
                            ctrl    <= CTRL_OFF;
                            busy    <= 1'b0;
`endif
                        end else begin
                            step <= next_step_s;
                            ctrl <= tbl_r[next_step_s];
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ctrl    <= CTRL_OFF;
                    step    <= STEP_FIRST;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prj_ctrl_seq.sv
// Directed bench for prj_ctrl_seq: vector table plus hand-written multi-cycle sequences.
module tb_prj_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [1:0] wr_data = 2'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] ctrl;
    logic [1:0] step;
    logic       busy;
    logic       done;

    logic       start1 = 1'b0;
    logic       stop1 = 1'b0;
    logic [1:0] ctrl1;
    logic [1:0] step1;
    logic       busy1;
    logic       done1;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic       acc_clr = 1'b0;
    logic [3:0] acc = 4'd0;

    always #5 clk = ~clk;

    prj_ctrl_seq #(.Nc(2), .STEPS(4), .DWELL(25)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .ctrl(ctrl), .step(step), .busy(busy), .done(done)
    );

    prj_ctrl_seq #(.Nc(2), .STEPS(4), .DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(1'b0), .wr_addr(2'd0), .wr_data(2'd0),
        .start(start1), .stop(stop1), .ctrl(ctrl1), .step(step1), .busy(busy1), .done(done1)
    );

    // prj_b step codes: 0 hold, 1 +1, 2 -2, 3 -1 (4-bit counter)
    always @(posedge clk) begin
        if (acc_clr) acc <= 4'd0;
        else case (ctrl)
            2'd1:    acc <= acc + 4'd1;
            2'd2:    acc <= acc + 4'd14;
            2'd3:    acc <= acc + 4'd15;
            default: acc <= acc;
        endcase
    end

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    typedef struct {
        logic       start;
        logic       stop;
        logic       wr_en;
        logic [1:0] wr_addr;
        logic [1:0] wr_data;
        int         wait_cyc;
        logic [1:0] ctrl;
        logic [1:0] step;
        logic       busy;
        logic       done;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int idx, input int c, input int s, input int b, input int d);
        chk({nm, "_ctrl"}, idx, int'(ctrl), c);
        chk({nm, "_step"}, idx, int'(step), s);
        chk({nm, "_busy"}, idx, int'(busy), b);
        chk({nm, "_done"}, idx, int'(done), d);
    endtask

    task automatic run_vec(input int idx);
        start   = vecs[idx].start;
        stop    = vecs[idx].stop;
        wr_en   = vecs[idx].wr_en;
        wr_addr = vecs[idx].wr_addr;
        wr_data = vecs[idx].wr_data;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        wr_en = 1'b0;
        tick(vecs[idx].wait_cyc);
        chk_out("vec", idx, int'(vecs[idx].ctrl), int'(vecs[idx].step),
                int'(vecs[idx].busy), int'(vecs[idx].done));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        logic [1:0] e1c [8];
        logic [1:0] e1s [8];
        logic       e1b [8];
        logic       e1d [8];

        // start stop wr_en addr data wait | ctrl step busy done
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0,  0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0,  0, 2'd0, 2'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 23, 2'd0, 2'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0,  0, 2'd1, 2'd1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24, 2'd2, 2'd2, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24, 2'd3, 2'd3, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 23, 2'd3, 2'd3, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0,  0, 2'd0, 2'd0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0,  0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd1,  0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd1, 2'd2,  0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 2'd2, 2'd3,  0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 2'd3, 2'd1,  0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0,  0, 2'd1, 2'd0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24, 2'd2, 2'd1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24, 2'd3, 2'd2, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 24, 2'd1, 2'd3, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 23, 2'd1, 2'd3, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0,  0, 2'd0, 2'd0, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0,  0, 2'd0, 2'd0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0,  4, 2'd0, 2'd0, 1'b0, 1'b0};

        // Reset state
        tick(2);
        chk_out("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick(1);

        // Default table single pass, then reprogrammed table {1,2,3,1}
        for (int i = 0; i < 9; i++) run_vec(i);
        acc_clr = 1'b1;
        tick(1);
        acc_clr = 1'b0;
        for (int i = 9; i < NV; i++) run_vec(i);
        chk("chain_acc", 0, int'(acc), 7);

        // Stop during entry 2: no done, restart from entry 0
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(59);
        chk_out("pre_stop", 0, 3, 2, 1, 0);
        d0 = done_cnt;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk_out("stop", 0, 0, 0, 0, 0);
        tick(5);
        chk("stop_no_done", 0, done_cnt - d0, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk_out("restart", 0, 1, 0, 1, 0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("restart_stop_busy", 0, int'(busy), 0);

        // Start while busy is ignored; busy lasts 100 cycles
        d0 = done_cnt;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            if (n == 10) start = 1'b1;
            tick(1);
            start = 1'b0;
            n++;
        end
        chk("busy_len", 0, n, 100);
        tick(1);
        chk("busy_len_done", 0, done_cnt - d0, 1);
        start = 1'b1;
        stop  = 1'b1;
        tick(3);
        chk_out("start_stop_idle", 0, 0, 0, 0, 0);
        start = 1'b0;
        stop  = 1'b0;
        tick(1);

        // Writes during entry 1: current entry unaffected, future entry picks up new code
        do_reset();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(25);
        chk_out("wr_e1", 0, 1, 1, 1, 0);
        tick(5);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 2'd0;
        tick(1);
        wr_addr = 2'd3; wr_data = 2'd2;
        tick(1);
        wr_en = 1'b0;
        chk_out("wr_e1_hold", 1, 1, 1, 1, 0);
        tick(18);
        chk_out("wr_e2", 0, 2, 2, 1, 0);
        tick(25);
        chk_out("wr_e3", 0, 2, 3, 1, 0);
        tick(25);
        chk_out("wr_end", 0, 0, 0, 0, 1);

        // Asynchronous reset at cycle 40 restores outputs and table
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(40);
        chk("rst40_pre_busy", 0, int'(busy), 1);
        chk("rst40_pre_step", 0, int'(step), 1);
        rst = 1'b1;
        #2;
        chk_out("rst40_async", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk_out("rst40_e0", 0, 0, 0, 1, 0);
        tick(25);
        chk_out("rst40_e1", 0, 1, 1, 1, 0);
        tick(50);
        chk_out("rst40_e3", 0, 3, 3, 1, 0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;

        // DWELL=1 instance: code changes every cycle
`ifdef PRJ_CTRL_SEQ_LOOP_EN
        e1c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        e1s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        e1b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        e1d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
        e1c = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        e1s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        e1b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        e1d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("d1_ctrl", i, int'(ctrl1), int'(e1c[i]));
            chk("d1_step", i, int'(step1), int'(e1s[i]));
            chk("d1_busy", i, int'(busy1), int'(e1b[i]));
            chk("d1_done", i, int'(done1), int'(e1d[i]));
            tick(1);
        end
        stop1 = 1'b1;
        tick(1);
        stop1 = 1'b0;
        chk("d1_stop_busy", 0, int'(busy1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
